// File: rtl/parity_scan_ctrl_pkg.sv
// Shared definitions for the parity ROM scanner and other parity-aware blocks.
package parity_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 8;

  // Expected stored parity bit for a word; zero-extension up to 32 bits leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_scan_ctrl_check.sv
// Combinational parity checker: flags a word whose stored parity bit disagrees with its contents.
module parity_check
  import parity_scan_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [DW-1:0] num,
  input  logic          parity,
  output logic          fail
);

  logic [31:0] word;

  assign word = 32'(num);
  assign fail = parity ^ parity_bit(word, ODD_PARITY);

endmodule

// File: rtl/parity_scan_ctrl.sv
// Walks every ROM address once per start request and collects parity error results.
module parity_scan_ctrl
  import parity_scan_ctrl_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     addr,
  input  logic [DW-1:0]     num,
  input  logic              parity,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       err_count,
  output logic [AW-1:0]     first_err_addr,
  output logic              first_err_valid,
  output logic [2**AW-1:0]  err_map
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  scan_state_t state, state_nxt;
  logic        fail;

  parity_check #(
    .DW         (DW),
    .ODD_PARITY (ODD_PARITY)
  ) u_check (
    .num    (num),
    .parity (parity),
    .fail   (fail)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (addr == LAST_ADDR) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk and result accumulation; results are cleared on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr            <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      err_map         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr            <= '0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
            err_map         <= '0;
          end
        end
        SCAN: begin
          if (fail) begin
            err_count     <= err_count + 1'b1;
            err_map[addr] <= 1'b1;
            if (!first_err_valid) begin
              first_err_addr  <= addr;
              first_err_valid <= 1'b1;
            end
          end
          if (addr != LAST_ADDR) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Bench for parity_scan_ctrl: even and odd parity instances scanning one shared ROM image.
module tb_parity_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rom_num [8];
  logic       rom_par [8];

  logic [2:0] addr0, addr1, fea0, fea1;
  logic       busy0, busy1, done0, done1, fev0, fev1;
  logic [3:0] cnt0, cnt1;
  logic [7:0] map0, map1;

  int total = 0;
  int bad   = 0;

  int       exp_cnt   [2];
  logic [7:0] exp_map [2];
  int       exp_first [2];
  bit       exp_fv    [2];

  always #5 clk = ~clk;

  parity_scan_ctrl #(.AW(3), .DW(8), .ODD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .addr(addr0),
    .num(rom_num[addr0]), .parity(rom_par[addr0]),
    .busy(busy0), .done(done0), .err_count(cnt0),
    .first_err_addr(fea0), .first_err_valid(fev0), .err_map(map0)
  );

  parity_scan_ctrl #(.AW(3), .DW(8), .ODD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .addr(addr1),
    .num(rom_num[addr1]), .parity(rom_par[addr1]),
    .busy(busy1), .done(done1), .err_count(cnt1),
    .first_err_addr(fea1), .first_err_valid(fev1), .err_map(map1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word is bad when the total number of ones (word, stored bit, odd flag) is odd.
  task automatic model();
    for (int k = 0; k < 2; k++) begin
      exp_cnt[k] = 0; exp_map[k] = 8'h00; exp_first[k] = 0; exp_fv[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if ((($countones(rom_num[i]) + int'(rom_par[i]) + k) % 2) == 1) begin
          exp_cnt[k]++;
          exp_map[k][i] = 1'b1;
          if (!exp_fv[k]) begin exp_first[k] = i; exp_fv[k] = 1'b1; end
        end
      end
    end
  endtask

  task automatic fill_good();
    for (int i = 0; i < 8; i++) begin
      rom_num[i] = 8'($urandom);
      rom_par[i] = 1'($countones(rom_num[i]) % 2);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_cnt0"},   cnt0, exp_cnt[0]);
    chk({tag, "_map0"},   map0, exp_map[0]);
    chk({tag, "_first0"}, fea0, exp_first[0]);
    chk({tag, "_fv0"},    fev0, exp_fv[0]);
    chk({tag, "_cnt1"},   cnt1, exp_cnt[1]);
    chk({tag, "_map1"},   map1, exp_map[1]);
    chk({tag, "_first1"}, fea1, exp_first[1]);
    chk({tag, "_fv1"},    fev1, exp_fv[1]);
  endtask

  // One full scan; optionally re-pulse start mid-scan or hold start high for a back-to-back scan.
  task automatic run_scan(input string tag, input int pulse_at, input bit hold);
    model();
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_addr"}, addr0, c - 1);
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_done"}, done0, 0);
      if (c == 1) begin
        chk({tag, "_clr_cnt"}, cnt0, 0);
        chk({tag, "_clr_map"}, map0, 0);
        chk({tag, "_clr_fv"},  fev0, 0);
        chk({tag, "_clr_cnt1"}, cnt1, 0);
      end
      if (pulse_at >= 0 && c == pulse_at + 1) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_done9"}, done0, 1);
    chk({tag, "_done9b"}, done1, 1);
    chk({tag, "_busy9"}, busy0, 0);
    chk({tag, "_addr9"}, addr0, 7);
    chk_results(tag);
    @(posedge clk); #1;
    chk({tag, "_done10"}, done0, 0);
    chk({tag, "_busy10"}, busy0, 0);
    chk({tag, "_hold_cnt"}, cnt0, exp_cnt[0]);
    if (hold) begin
      @(posedge clk); #1;
      chk({tag, "_b2b_busy"}, busy0, 1);
      chk({tag, "_b2b_addr"}, addr0, 0);
      start = 1'b0;
      for (int w = 0; w < 20 && !done0; w++) begin @(posedge clk); #1; end
      chk({tag, "_b2b_done"}, done0, 1);
      chk_results({tag, "_b2b"});
    end else begin
      @(posedge clk); #1;
      chk({tag, "_noextra"}, busy0, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 8; i++) begin rom_num[i] = 8'h36; rom_par[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr0, 0); chk("rst_busy", busy0, 0); chk("rst_done", done0, 0);
    chk("rst_cnt", cnt0, 0); chk("rst_first", fea0, 0); chk("rst_fv", fev0, 0);
    chk("rst_map", map0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_scan("allgood", -1, 1'b0);
    chk("allgood_odd_cnt", cnt1, 8);

    rom_par[5] = ~rom_par[5];
    run_scan("par5", -1, 1'b0);

    fill_good();
    rom_num[1] = rom_num[1] ^ 8'h10;
    rom_num[6] = rom_num[6] ^ 8'h01;
    run_scan("bad16a", -1, 1'b0);
    run_scan("bad16b", -1, 1'b0);

    for (int i = 0; i < 8; i++) rom_par[i] = ~rom_par[i];
    rom_num[1] = rom_num[1] ^ 8'h10;
    rom_num[6] = rom_num[6] ^ 8'h01;
    run_scan("allbad", -1, 1'b0);

    fill_good();
    rom_par[3] = ~rom_par[3];
    run_scan("midstart", 3, 1'b0);

    // Reset while the scan is at address 3.
    fill_good();
    rom_par[2] = ~rom_par[2];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_addr3", addr0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_addr", addr0, 0); chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0); chk("midrst_cnt", cnt0, 0);
    chk("midrst_map", map0, 0);   chk("midrst_fv", fev0, 0);
    chk("midrst_first", fea0, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done0 || done1) dones++;
      @(posedge clk); #1;
    end
    chk("midrst_nodone", dones, 0);
    run_scan("postrst", -1, 1'b0);

    fill_good();
    rom_par[4] = ~rom_par[4];
    run_scan("held", -1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) begin
        rom_num[i] = 8'($urandom);
        rom_par[i] = 1'($urandom);
      end
      run_scan("rand", -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_scan_ctrl.md
Name: parity_scan_ctrl

Overview:
Sequential scanner that sits directly upstream of the 8-entry, 9-bit parity-word ROM. It drives the ROM address. It checks each returned 8-bit word against its stored parity bit. On a start request it walks every address once, then reports the error count, the first failing address and a per-address error map, with a start/done handshake.

Parameters:
AW, 3, ROM address width; depth = 2**AW entries.
DW, 8, data word width, excluding the parity bit.
ODD_PARITY, 0, 0 = even parity (stored bit = XOR of the word); 1 = odd parity (stored bit = ~XOR of the word).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  scan request; sampled only in IDLE.
addr  output  AW  ROM address; registered.
num  input  DW  ROM data word; combinational response to addr.
parity  input  1  ROM stored parity bit for addr.
busy  output  1  high in SCAN.
done  output  1  one-cycle pulse when results are final.
err_count  output  AW+1  number of failing addresses in the last scan (0..2**AW).
first_err_addr  output  AW  lowest failing address; 0 if none.
first_err_valid  output  1  at least one failure in the last scan.
err_map  output  2**AW  bit i set = address i failed.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values: state=IDLE, addr=0, busy=0, done=0, err_count=0, first_err_addr=0, first_err_valid=0, err_map=0.
- rst overrides everything, including mid-scan: on the next edge all outputs return to reset values and no done is issued.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 → SCAN, addr=0, busy=1.
  - Results are cleared on this same edge (err_count, err_map, first_err_* = 0).
  - start=0 → stay; results hold the previous scan's values.
- SCAN, each cycle:
  - ROM is combinational, so num/parity correspond to the current addr in the same cycle.
  - Fail condition: (^num ^ parity ^ ODD_PARITY) == 1.
  - On fail: err_count += 1, err_map[addr] = 1. If first_err_valid=0, set first_err_addr=addr and first_err_valid=1.
  - If addr == 2**AW-1 → DONE, busy=0, addr held. Otherwise addr += 1.
- DONE: done=1 for exactly this one cycle, then → IDLE unconditionally.
- start handling:
  - start while in SCAN or DONE is ignored; it is not queued.
  - start must be re-asserted in IDLE to begin a new scan.
  - start held high continuously produces back-to-back scans separated by one IDLE cycle.
- Latency: start sampled at edge 0 → addresses 0..2**AW-1 presented in cycles 1..2**AW → done high in cycle 2**AW+1 (cycle 9 for defaults).
- Width rule: err_count is AW+1 bits, so the all-fail case (8) does not wrap.
- Results are stable from the done cycle until the next accepted start or rst.

Decomposition:
- Shared package:
  - scan state enum (IDLE, SCAN, DONE);
  - default AW/DW constants;
  - a parity-compute function (XOR-reduce plus odd/even select), reused by other parity-aware blocks.
- One natural sub-module: parity_check. It is combinational: inputs num, parity and ODD_PARITY; output fail. It is instantiated once; the FSM, counters and result registers stay in parity_scan_ctrl.

Test Plan:
1. ROM model with all 8 words having correct even parity (e.g. word 0x36, parity 0), pulse start → addr steps 0..7 in cycles 1..8; done in cycle 9; err_count=0, first_err_valid=0, err_map=0x00.
2. Parity bit flipped at address 5 only → err_count=1, first_err_addr=5, first_err_valid=1, err_map=0x20.
3. Bad words at addresses 1 and 6 → err_count=2, first_err_addr=1, err_map=0x42; second start clears results before the rescan.
4. All 8 words bad → err_count=8 (4'b1000), first_err_addr=0, err_map=0xFF. Same all-good ROM as scenario 1 with ODD_PARITY=1 → also err_count=8.
5. start pulsed again during SCAN at addr=3 → ignored; single done pulse at cycle 9; no extra scan follows.
6. rst asserted while addr=3 in SCAN → next edge: addr=0, busy=0, done never pulses, all results 0; a new start then completes normally.
